instr_fetch_unit: RTL

//  Fetch-side producer for the instruction register. Holds the program counter
//  and issues req/ack reads to instruction memory. Each returned word drives
//  out_instruction, and fetch pulses for one cycle so the instruction register latches it.

---
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch producer: owns the PC, issues req/ack reads to instruction memory,
// and pulses fetch for one cycle per delivered word. Redirects squash in-flight reads.
module instr_fetch_unit #(
    parameter int ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              advance,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       out_instruction,
    output logic              fetch,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              busy
);

    // GAP is the single idle cycle between a discarded read and its re-issue.
    typedef enum logic [1:0] {IDLE, REQ, HOLD, GAP} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pending_pc_reg;
    logic              squash_reg;
    logic              mem_req_reg;
    logic              fetch_reg;
    logic [31:0]       instr_reg;
    logic [ADDR_W-1:0] fetch_pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            pending_pc_reg <= RESET_PC;
            squash_reg     <= 1'b0;
            mem_req_reg    <= 1'b0;
            fetch_reg      <= 1'b0;
            instr_reg      <= '0;
            fetch_pc_reg   <= RESET_PC;
        end else begin
            fetch_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (redirect)
                        pc_reg <= redirect_pc;
                    if (en) begin
                        state_reg   <= REQ;
                        mem_req_reg <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        if (redirect) begin
                            pc_reg     <= redirect_pc;
                            squash_reg <= 1'b0;
                            state_reg  <= GAP;
                        end else if (squash_reg) begin
                            pc_reg     <= pending_pc_reg;
                            squash_reg <= 1'b0;
                            state_reg  <= GAP;
                        end else begin
                            instr_reg    <= mem_rdata;
                            fetch_pc_reg <= pc_reg;
                            fetch_reg    <= 1'b1;
                            state_reg    <= HOLD;
                        end
                    end else if (redirect) begin
                        // Address must stay put until ack; remember the target instead.
                        pending_pc_reg <= redirect_pc;
                        squash_reg     <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_reg      <= redirect_pc;
                        state_reg   <= REQ;
                        mem_req_reg <= 1'b1;
                    end else if (advance) begin
                        pc_reg      <= pc_reg + ADDR_W'(PC_STEP);
                        state_reg   <= REQ;
                        mem_req_reg <= 1'b1;
                    end
                end
                GAP: begin
                    if (redirect)
                        pc_reg <= redirect_pc;
                    state_reg   <= REQ;
                    mem_req_reg <= 1'b1;
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req         = mem_req_reg;
    assign mem_addr        = pc_reg;
    assign busy            = mem_req_reg;
    assign fetch           = fetch_reg;
    assign out_instruction = instr_reg;
    assign fetch_pc        = fetch_pc_reg;

endmodule
